l5_dense_engine: RTL and testbench
==================================

// Module: l5_dense_engine
// PURPOSE
//  Final fully-connected stage: owns the l5 input memory (written by the scheduler
//  via wantwrite/index), computes NUM_OUTPUT dot products over NUM_INPUT activations
//  on a compute_start pulse, and returns compute_done to the pipelined scheduler.
//  Holds NUM_OUTPUT class scores readable on a separate port.
// PARAMETERS
//  DATA_SIZE   64   signed two's-complement activation/weight width
//  FRAC_BITS   16   fractional bits (Q format) of activations, weights, results
//  NUM_INPUT   800  activations per output (l4 output flattened, 32x5x5)
//  NUM_OUTPUT  10   output neurons
//  ACC_GUARD   16   extra accumulator bits; ACC_W = DATA_SIZE+ACC_GUARD
// PORTS
//  clk              in   1          rising-edge clock
//  reset_n          in   1          asynchronous, active-low reset
//  inmem_wantwrite  in   1          write enable for input memory
//  inmem_index      in   16         input memory write address
//  inmem_wdata      in   DATA_SIZE  activation being written
//  compute_start    in   1          1-cycle start pulse
//  compute_done     out  1          high = idle, results valid / nothing pending
//  w_addr           out  16         weight ROM address, o*NUM_INPUT+i
//  w_data           in   DATA_SIZE  weight, valid 1 cycle after w_addr
//  out_index        in   4          result read address
//  out_data         out  DATA_SIZE  result[out_index], combinational read
//  wr_err           out  1          sticky: write attempted while busy or index>=NUM_INPUT
// BEHAVIOUR
//  Reset: compute_done=1, w_addr=0, wr_err=0, state IDLE, counters 0; result
//   memory and input memory contents not cleared.
//  Writes: when inmem_wantwrite and IDLE and index<NUM_INPUT, mem[index]<=wdata at
//   the edge. Otherwise dropped and wr_err set (cleared only by reset).
//  States: IDLE -> RUN on compute_start (compute_done drops at that same edge).
//   RUN issues one (o,i) address per cycle, i fastest, o=0..NUM_OUTPUT-1, no stalls.
//   RUN -> DRAIN after last address; DRAIN -> IDLE when the last result is written.
//  Pipeline: S0 addr (w_addr, input read addr) -> S1 operands -> S2 product reg ->
//   S3 accumulate. Accumulator loads (not adds) on i==0. On i==NUM_INPUT-1 the sum
//   is saturated and written to result[o] on the following edge.
//  Latency: compute_done reasserts exactly NUM_OUTPUT*NUM_INPUT+4 cycles after the
//   start edge (8004 at defaults).
//  Arithmetic: product 2*DATA_SIZE signed, arithmetic shift right FRAC_BITS,
//   sign-extended into ACC_W; final value saturated to [-2^(DATA_SIZE-1),
//   2^(DATA_SIZE-1)-1]. No bias term.
//  compute_start while not IDLE: ignored. Start and wantwrite same cycle in IDLE:
//   write lands, compute starts, and the write is visible to the computation.
//  reset_n low mid-RUN: abort immediately; partial results undefined; done=1.
//  out_index>=NUM_OUTPUT: out_data=0.
// CONFIGURATION
//  ARGMAX_EN defined: adds out port class_id[3:0] + class_valid; running argmax
//   updated as each result is written (strict >, lowest index wins ties);
//   class_valid cleared at start edge, set with compute_done rise; reset 0/0.
//  Undefined: ports absent, no comparator logic.
// STRUCTURE
//  dnn_pkg: DATA_SIZE, FRAC_BITS, ACC_W, saturate function, state enum
//   (IDLE/RUN/DRAIN).
//  Sub-module fc_mac_pipe: S2/S3 multiply-shift-accumulate-saturate datapath,
//   first/last flags in, result+valid out. Top keeps counters, memories, FSM.
// TESTING
//  1 Reset, write x[i]=1.0 all i, ROM w=0.5 for o=3 else 0, start -> result[3]=400.0,
//    others 0, done rises at cycle 8004.
//  2 w=1.0 all, x[i]=i (Q) -> each result = 319600.0; no saturation.
//  3 x=w=2^(DATA_SIZE-1-FRAC_BITS)-1 -> all results saturate to max positive;
//    negative mirror -> min.
//  4 wantwrite during RUN and index=800 in IDLE -> memory unchanged, wr_err=1.
//  5 reset_n low at cycle 4000 of RUN -> done=1 asynchronously; new start gives
//    correct results.
//  6 ARGMAX_EN: results peak at o=7, tie at o=2/5 variant -> class_id=7, tie gives 2.

Source files
------------

// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared widths, FSM states and saturation helpers for the dense engine
package dnn_pkg;

    localparam int DATA_SIZE = 64;
    localparam int FRAC_BITS = 16;
    localparam int ACC_GUARD = 16;
    localparam int ACC_W     = DATA_SIZE + ACC_GUARD;
    localparam int PROD_W    = 2 * DATA_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic signed [ACC_W-1:0] sat_prod(input logic signed [PROD_W-1:0] v);
        logic [PROD_W-ACC_W:0] top;
        top = v[PROD_W-1:ACC_W-1];
        if (top == {(PROD_W-ACC_W+1){v[PROD_W-1]}}) begin
            return v[ACC_W-1:0];
        end
        return v[PROD_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    // Accumulator clamps rather than wraps, so a runaway sum still saturates with the right sign.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] == s[ACC_W-1]) begin
            return s[ACC_W-1:0];
        end
        return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    function automatic logic signed [DATA_SIZE-1:0] saturate(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-DATA_SIZE:0] top;
        top = v[ACC_W-1:DATA_SIZE-1];
        if (top == {(ACC_W-DATA_SIZE+1){v[ACC_W-1]}}) begin
            return v[DATA_SIZE-1:0];
        end
        return v[ACC_W-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}} : {1'b0, {(DATA_SIZE-1){1'b1}}};
    endfunction

endpackage

// File: rtl/fc_mac_pipe.sv
// rtl/fc_mac_pipe.sv - product register (S2) and accumulate/saturate stage (S3) of the dense engine
module fc_mac_pipe
    import dnn_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic [3:0]                  in_idx,
    input  logic signed [DATA_SIZE-1:0] in_a,
    input  logic signed [DATA_SIZE-1:0] in_b,
    output logic                        res_valid,
    output logic [3:0]                  res_idx,
    output logic [DATA_SIZE-1:0]        res_data
);

    logic signed [PROD_W-1:0] prod_full;
    logic signed [ACC_W-1:0]  prod_d, prod_q, acc_d, acc_q;
    logic                     p_valid_d, p_valid_q, p_first_d, p_first_q, p_last_d, p_last_q;
    logic [3:0]               p_idx_d, p_idx_q, fin_idx_d, fin_idx_q;
    logic                     fin_valid_d, fin_valid_q;

    always_comb begin
        prod_full   = in_a * in_b;
        prod_d      = sat_prod(prod_full >>> FRAC_BITS);
        p_valid_d   = in_valid;
        p_first_d   = in_first;
        p_last_d    = in_last;
        p_idx_d     = in_idx;
        acc_d       = acc_q;
        if (p_valid_q) begin
            acc_d = p_first_q ? prod_q : sat_add(acc_q, prod_q);
        end
        fin_valid_d = p_valid_q & p_last_q;
        fin_idx_d   = p_idx_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q      <= '0;
            p_valid_q   <= 1'b0;
            p_first_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_idx_q     <= '0;
            acc_q       <= '0;
            fin_valid_q <= 1'b0;
            fin_idx_q   <= '0;
        end else begin
            prod_q      <= prod_d;
            p_valid_q   <= p_valid_d;
            p_first_q   <= p_first_d;
            p_last_q    <= p_last_d;
            p_idx_q     <= p_idx_d;
            acc_q       <= acc_d;
            fin_valid_q <= fin_valid_d;
            fin_idx_q   <= fin_idx_d;
        end
    end

    assign res_valid = fin_valid_q;
    assign res_idx   = fin_idx_q;
    assign res_data  = saturate(acc_q);

endmodule

// File: rtl/l5_dense_engine.sv
// rtl/l5_dense_engine.sv - final fully-connected layer: input memory, address FSM, result store; ARGMAX_EN adds class output
module l5_dense_engine
    import dnn_pkg::*;
#(
    parameter int NUM_INPUT  = 800,
    parameter int NUM_OUTPUT = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 inmem_wantwrite,
    input  logic [15:0]          inmem_index,
    input  logic [DATA_SIZE-1:0] inmem_wdata,
    input  logic                 compute_start,
    output logic                 compute_done,
    output logic [15:0]          w_addr,
    input  logic [DATA_SIZE-1:0] w_data,
    input  logic [3:0]           out_index,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 wr_err
`ifdef ARGMAX_EN
    ,
    output logic [3:0]           class_id,
    output logic                 class_valid
`endif
);

    localparam int IW = $clog2(NUM_INPUT);

    state_e               state_d, state_q;
    logic [IW-1:0]        i_cnt_d, i_cnt_q, s0_i_d, s0_i_q;
    logic [3:0]           o_cnt_d, o_cnt_q, s0_o_d, s0_o_q, s1_o_d, s1_o_q;
    logic [15:0]          addr_cnt_d, addr_cnt_q, w_addr_d, w_addr_q;
    logic                 s0_valid_d, s0_valid_q, s0_first_d, s0_first_q, s0_last_d, s0_last_q;
    logic                 s1_valid_d, s1_valid_q, s1_first_d, s1_first_q, s1_last_d, s1_last_q;
    logic                 done_d, done_q, wr_err_d, wr_err_q, mem_we;
    logic [DATA_SIZE-1:0] x_rd_d, x_rd_q;
    logic                 res_valid;
    logic [3:0]           res_idx;
    logic [DATA_SIZE-1:0] res_data;

    logic [DATA_SIZE-1:0] in_mem  [NUM_INPUT];
    logic [DATA_SIZE-1:0] res_mem [NUM_OUTPUT];

    always_comb begin
        state_d    = state_q;
        i_cnt_d    = i_cnt_q;
        o_cnt_d    = o_cnt_q;
        addr_cnt_d = addr_cnt_q;
        w_addr_d   = w_addr_q;
        s0_valid_d = 1'b0;
        s0_first_d = s0_first_q;
        s0_last_d  = s0_last_q;
        s0_o_d     = s0_o_q;
        s0_i_d     = s0_i_q;
        s1_valid_d = s0_valid_q;
        s1_first_d = s0_first_q;
        s1_last_d  = s0_last_q;
        s1_o_d     = s0_o_q;
        x_rd_d     = in_mem[s0_i_q];
        done_d     = done_q;
        mem_we     = inmem_wantwrite && (state_q == ST_IDLE) && (inmem_index < 16'(NUM_INPUT));
        wr_err_d   = wr_err_q | (inmem_wantwrite & ~mem_we);
        case (state_q)
            ST_IDLE: begin
                if (compute_start) begin
                    state_d    = ST_RUN;
                    done_d     = 1'b0;
                    i_cnt_d    = '0;
                    o_cnt_d    = '0;
                    addr_cnt_d = '0;
                end
            end
            ST_RUN: begin
                w_addr_d   = addr_cnt_q;
                s0_valid_d = 1'b1;
                s0_first_d = (i_cnt_q == '0);
                s0_last_d  = (i_cnt_q == IW'(NUM_INPUT - 1));
                s0_o_d     = o_cnt_q;
                s0_i_d     = i_cnt_q;
                addr_cnt_d = addr_cnt_q + 16'd1;
                if (i_cnt_q == IW'(NUM_INPUT - 1)) begin
                    i_cnt_d = '0;
                    if (o_cnt_q == 4'(NUM_OUTPUT - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        o_cnt_d = o_cnt_q + 4'd1;
                    end
                end else begin
                    i_cnt_d = i_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (res_valid && (res_idx == 4'(NUM_OUTPUT - 1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            i_cnt_q    <= '0;
            o_cnt_q    <= '0;
            addr_cnt_q <= '0;
            w_addr_q   <= '0;
            s0_valid_q <= 1'b0;
            s0_first_q <= 1'b0;
            s0_last_q  <= 1'b0;
            s0_o_q     <= '0;
            s0_i_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_o_q     <= '0;
            done_q     <= 1'b1;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_cnt_q    <= i_cnt_d;
            o_cnt_q    <= o_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            w_addr_q   <= w_addr_d;
            s0_valid_q <= s0_valid_d;
            s0_first_q <= s0_first_d;
            s0_last_q  <= s0_last_d;
            s0_o_q     <= s0_o_d;
            s0_i_q     <= s0_i_d;
            s1_valid_q <= s1_valid_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            s1_o_q     <= s1_o_d;
            done_q     <= done_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // Storage arrays are deliberately left out of reset; x_rd_q lines up with the weight ROM latency.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            in_mem[inmem_index[IW-1:0]] <= inmem_wdata;
        end
        if (res_valid) begin
            res_mem[res_idx] <= res_data;
        end
        x_rd_q <= x_rd_d;
    end

    fc_mac_pipe u_mac (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (s1_valid_q),
        .in_first  (s1_first_q),
        .in_last   (s1_last_q),
        .in_idx    (s1_o_q),
        .in_a      (x_rd_q),
        .in_b      (w_data),
        .res_valid (res_valid),
        .res_idx   (res_idx),
        .res_data  (res_data)
    );

    always_comb begin
        out_data = '0;
        if (out_index < 4'(NUM_OUTPUT)) begin
            out_data = res_mem[out_index];
        end
    end

    assign compute_done = done_q;
    assign w_addr       = w_addr_q;
    assign wr_err       = wr_err_q;

`ifdef ARGMAX_EN
    logic [DATA_SIZE-1:0] best_d, best_q;
    logic [3:0]           class_id_d, class_id_q;
    logic                 class_valid_d, class_valid_q;

    always_comb begin
        best_d        = best_q;
        class_id_d    = class_id_q;
        class_valid_d = class_valid_q;
        if (state_q == ST_IDLE && compute_start) begin
            class_valid_d = 1'b0;
        end
        if (res_valid && (res_idx == '0 || $signed(res_data) > $signed(best_q))) begin
            best_d     = res_data;
            class_id_d = res_idx;
        end
        if (state_q == ST_DRAIN && done_d) begin
            class_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_q        <= '0;
            class_id_q    <= '0;
            class_valid_q <= 1'b0;
        end else begin
            best_q        <= best_d;
            class_id_q    <= class_id_d;
            class_valid_q <= class_valid_d;
        end
    end

    assign class_id    = class_id_q;
    assign class_valid = class_valid_q;
`endif

endmodule

// File: tb/tb_l5_dense_engine.sv
// tb/tb_l5_dense_engine.sv - directed bench for l5_dense_engine with a registered weight ROM model
module tb_l5_dense_engine;

    localparam logic [63:0] ONE  = 64'h0000_0000_0001_0000;
    localparam logic [63:0] BIG  = 64'h7FFF_FFFF_FFFF_0000;
    localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        inmem_wantwrite = 1'b0;
    logic [15:0] inmem_index = '0;
    logic [63:0] inmem_wdata = '0;
    logic        compute_start = 1'b0;
    logic        compute_done;
    logic [15:0] w_addr;
    logic [63:0] w_data = '0;
    logic [3:0]  out_index = '0;
    logic [63:0] out_data;
    logic        wr_err;
`ifdef ARGMAX_EN
    logic [3:0]  class_id;
    logic        class_valid;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int rom_mode = 0;
    int cyc;
    logic [63:0] exp_v;

    l5_dense_engine dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .inmem_wantwrite (inmem_wantwrite),
        .inmem_index     (inmem_index),
        .inmem_wdata     (inmem_wdata),
        .compute_start   (compute_start),
        .compute_done    (compute_done),
        .w_addr          (w_addr),
        .w_data          (w_data),
        .out_index       (out_index),
        .out_data        (out_data),
        .wr_err          (wr_err)
`ifdef ARGMAX_EN
        ,
        .class_id        (class_id),
        .class_valid     (class_valid)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rom(input logic [15:0] a);
        int o;
        o = int'(a) / 800;
        case (rom_mode)
            1: return (o == 3) ? 64'h0000_0000_0000_8000 : 64'h0;
            2: return ONE;
            3: return BIG;
            4: return (o == 7) ? 3 * ONE : ONE;
            5: return (o == 2 || o == 5) ? 2 * ONE : ONE;
            default: return 64'h0;
        endcase
    endfunction

    always @(posedge clk) w_data <= rom(w_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] xval(input int mode, input int i);
        case (mode)
            0: return ONE;
            1: return 64'(i) << 16;
            2: return BIG;
            default: return -BIG;
        endcase
    endfunction

    task automatic load_x(input int mode);
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            inmem_wantwrite = 1'b1;
            inmem_index     = 16'(i);
            inmem_wdata     = xval(mode, i);
        end
        @(negedge clk);
        inmem_wantwrite = 1'b0;
    endtask

    // inject: mid-run illegal write plus a spurious start; wr_start: write x[799]=0 alongside start
    task automatic start_run(input bit inject, input bit wr_start, output int cycles);
        @(negedge clk);
        compute_start = 1'b1;
        if (wr_start) begin
            inmem_wantwrite = 1'b1;
            inmem_index     = 16'd799;
            inmem_wdata     = 64'h0;
        end
        @(posedge clk);
        #1;
        compute_start   = 1'b0;
        inmem_wantwrite = 1'b0;
        cycles = 0;
        check("done_drop", {63'b0, compute_done}, 64'd0);
        while (!compute_done && cycles < 9000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (inject && cycles == 100) begin
                compute_start   = 1'b1;
                inmem_wantwrite = 1'b1;
                inmem_index     = 16'd5;
                inmem_wdata     = 64'hDEAD_0000;
            end else if (inject && cycles == 101) begin
                compute_start   = 1'b0;
                inmem_wantwrite = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] exp);
        for (int o = 0; o < 10; o++) begin
            out_index = 4'(o);
            #1;
            check($sformatf("%s[%0d]", tag, o), out_data, exp);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", {63'b0, compute_done}, 64'd1);
        check("rst_waddr", {48'b0, w_addr}, 64'd0);
        check("rst_wrerr", {63'b0, wr_err}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // one-hot weights on output 3, x = 1.0
        load_x(0);
        rom_mode = 1;
        start_run(1'b0, 1'b0, cyc);
        check("t1_latency", 64'(cyc), 64'd8004);
        for (int o = 0; o < 10; o++) begin
            out_index = 4'(o);
            #1;
            exp_v = (o == 3) ? 64'd400 << 16 : 64'd0;
            check($sformatf("t1_res[%0d]", o), out_data, exp_v);
        end
        out_index = 4'd12;
        #1;
        check("oob_read", out_data, 64'd0);

        // x[i] = i, w = 1.0; illegal write and spurious start mid-run
        load_x(1);
        rom_mode = 2;
        start_run(1'b1, 1'b0, cyc);
        check("t2_latency", 64'(cyc), 64'd8004);
        check("t2_wrerr", {63'b0, wr_err}, 64'd1);
        check_all("t2_res", 64'd319600 << 16);

        // reset clears wr_err; out-of-range index sets it
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("t4_wrerr_clr", {63'b0, wr_err}, 64'd0);
        @(negedge clk);
        inmem_wantwrite = 1'b1;
        inmem_index     = 16'd800;
        inmem_wdata     = 64'h1234;
        @(negedge clk);
        inmem_wantwrite = 1'b0;
        check("t4_wrerr_oob", {63'b0, wr_err}, 64'd1);

        // abort mid-run, then a clean rerun
        @(negedge clk);
        compute_start = 1'b1;
        @(negedge clk);
        compute_start = 1'b0;
        repeat (4000) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_done_async", {63'b0, compute_done}, 64'd1);
        check("t5_waddr", {48'b0, w_addr}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        start_run(1'b0, 1'b0, cyc);
        check("t5_latency", 64'(cyc), 64'd8004);
        check_all("t5_res", 64'd319600 << 16);

        // write of x[799]=0 in the start cycle must be seen by the computation
        start_run(1'b0, 1'b1, cyc);
        check_all("t7_res", 64'd318801 << 16);

        // saturation both ways
        load_x(2);
        rom_mode = 3;
        start_run(1'b0, 1'b0, cyc);
        check_all("t3_max", SMAX);
        load_x(3);
        start_run(1'b0, 1'b0, cyc);
        check_all("t3_min", SMIN);

`ifdef ARGMAX_EN
        load_x(0);
        rom_mode = 4;
        start_run(1'b0, 1'b0, cyc);
        check("t6_peak_id", {60'b0, class_id}, 64'd7);
        check("t6_peak_valid", {63'b0, class_valid}, 64'd1);
        rom_mode = 5;
        start_run(1'b0, 1'b0, cyc);
        check("t6_tie_id", {60'b0, class_id}, 64'd2);
        check("t6_tie_valid", {63'b0, class_valid}, 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
